// File: rtl/servo_multi.sv
// N-channel hobby-servo PWM generator: one shared microsecond prescaler and frame
// counter, per-channel clamped and optionally slew-limited pulse widths.
module servo_multi #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned CH_W      = 2,
    parameter int unsigned W         = 16,
    parameter int unsigned CLK_F     = 100,
    parameter int unsigned PERIOD_US = 20000,
    parameter int unsigned MIN_US    = 500,
    parameter int unsigned MAX_US    = 2500,
    parameter int unsigned RESET_US  = 1500,
    parameter int unsigned SLEW_US   = 0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            wr_en,
    input  logic [CH_W-1:0] wr_ch,
    input  logic [W-1:0]    wr_data,
    input  logic [N_CH-1:0] ch_enable,
    output logic [N_CH-1:0] CONTROL_PIN,
    output logic            frame_start
);

    localparam int unsigned PW = (CLK_F > 1) ? $clog2(CLK_F) : 1;
    localparam int unsigned DW = W + 1;

    logic [PW-1:0]   presc_q, presc_d;
    logic [W-1:0]    count_q, count_d;
    logic [W-1:0]    target_q [N_CH];
    logic [W-1:0]    target_d [N_CH];
    logic [W-1:0]    active_q [N_CH];
    logic [W-1:0]    active_d [N_CH];
    logic [N_CH-1:0] en_q, en_d;
    logic [N_CH-1:0] pin_q, pin_d;
    logic            frame_start_q, frame_start_d;
    logic            tick_c;
    logic            load_c;

    // Clamp the target, then step the active width toward it by at most SLEW_US.
    function automatic logic [W-1:0] next_active(input logic [W-1:0] tgt,
                                                 input logic [W-1:0] act);
        logic [W-1:0]     c;
        logic signed [W:0] d;
        c = tgt;
        if (tgt < W'(MIN_US)) begin
            c = W'(MIN_US);
        end else if (tgt > W'(MAX_US)) begin
            c = W'(MAX_US);
        end
        d = $signed({1'b0, c}) - $signed({1'b0, act});
        if (SLEW_US == 0) begin
            return c;
        end else if (d > $signed(DW'(SLEW_US))) begin
            return act + W'(SLEW_US);
        end else if (d < -$signed(DW'(SLEW_US))) begin
            return act - W'(SLEW_US);
        end
        return c;
    endfunction

    always_comb begin
        tick_c        = (presc_q == PW'(CLK_F - 1));
        load_c        = tick_c && (count_q == W'(PERIOD_US - 1));
        presc_d       = tick_c ? '0 : presc_q + PW'(1);
        count_d       = count_q;
        frame_start_d = load_c;
        en_d          = load_c ? ch_enable : en_q;
        if (load_c) begin
            count_d = '0;
        end else if (tick_c) begin
            count_d = count_q + W'(1);
        end
        // The load reads target_q, so a write on the load edge lands next frame.
        for (int i = 0; i < N_CH; i++) begin
            target_d[i] = target_q[i];
            active_d[i] = active_q[i];
            if (wr_en && (wr_ch == CH_W'(i))) begin
                target_d[i] = wr_data;
            end
            if (load_c) begin
                active_d[i] = next_active(target_q[i], active_q[i]);
            end
            pin_d[i] = en_q[i] && (count_q < active_q[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_q       <= '0;
            count_q       <= '0;
            en_q          <= '0;
            pin_q         <= '0;
            frame_start_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                target_q[i] <= W'(RESET_US);
                active_q[i] <= W'(RESET_US);
            end
        end else begin
            presc_q       <= presc_d;
            count_q       <= count_d;
            en_q          <= en_d;
            pin_q         <= pin_d;
            frame_start_q <= frame_start_d;
            for (int i = 0; i < N_CH; i++) begin
                target_q[i] <= target_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign CONTROL_PIN = pin_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_servo_multi.sv
// Scoreboard bench for servo_multi: two instances (slew off / slew 8) share stimulus;
// a per-frame reference model predicts high times, monitors measure each frame.
module tb_servo_multi;

    localparam int unsigned NCH  = 4;
    localparam int unsigned CHW  = 3;
    localparam int unsigned WW   = 16;
    localparam int unsigned CF   = 2;
    localparam int unsigned PER  = 100;
    localparam int unsigned MINU = 10;
    localparam int unsigned MAXU = 60;
    localparam int unsigned RSTU = 30;
    localparam int unsigned PCF  = PER * CF;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           wr_en = 1'b0;
    logic [CHW-1:0] wr_ch = '0;
    logic [WW-1:0]  wr_data = '0;
    logic [NCH-1:0] ch_enable = '0;
    logic [NCH-1:0] pin0, pin1;
    logic           fs0, fs1;

    always #5 clk = ~clk;

    servo_multi #(.N_CH(NCH), .CH_W(CHW), .W(WW), .CLK_F(CF), .PERIOD_US(PER),
                  .MIN_US(MINU), .MAX_US(MAXU), .RESET_US(RSTU), .SLEW_US(0)) u_dut0 (
        .CLK(clk), .RST(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .ch_enable(ch_enable), .CONTROL_PIN(pin0), .frame_start(fs0));

    servo_multi #(.N_CH(NCH), .CH_W(CHW), .W(WW), .CLK_F(CF), .PERIOD_US(PER),
                  .MIN_US(MINU), .MAX_US(MAXU), .RESET_US(RSTU), .SLEW_US(8)) u_dut1 (
        .CLK(clk), .RST(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .ch_enable(ch_enable), .CONTROL_PIN(pin1), .frame_start(fs1));

    // Expected high-time (in clock cycles) per channel for one frame window.
    typedef struct packed {
        logic [NCH-1:0][15:0] hi;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    int tgt_m [2][NCH];
    int act_m [2][NCH];
    int slew_m [2] = '{0, 8};
    int edge_n = 0;
    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int k, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, k, act, exp, $time);
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic push_exp(input int k, input exp_t e);
        if (k == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
    endtask

    function automatic exp_t qfront(input int k);
        return (k == 0) ? exp_q0[0] : exp_q1[0];
    endfunction

    task automatic qpop(input int k, output exp_t e);
        if (k == 0) e = exp_q0.pop_front();
        else e = exp_q1.pop_front();
    endtask

    // Reference model: effect of the upcoming clock edge, given the driven inputs.
    task automatic model_edge();
        exp_t e;
        int   c, d;
        if (rst) begin
            edge_n = 0;
            exp_q0.delete();
            exp_q1.delete();
            for (int k = 0; k < 2; k++) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    tgt_m[k][ch] = RSTU;
                    act_m[k][ch] = RSTU;
                end
                e = '0;
                push_exp(k, e);
            end
            return;
        end
        edge_n++;
        if (edge_n % PCF == 0) begin
            for (int k = 0; k < 2; k++) begin
                e = '0;
                for (int ch = 0; ch < NCH; ch++) begin
                    c = tgt_m[k][ch];
                    if (c < int'(MINU)) c = MINU;
                    if (c > int'(MAXU)) c = MAXU;
                    d = c - act_m[k][ch];
                    if (slew_m[k] != 0 && d > slew_m[k]) d = slew_m[k];
                    if (slew_m[k] != 0 && d < -slew_m[k]) d = -slew_m[k];
                    act_m[k][ch] = act_m[k][ch] + d;
                    if (ch_enable[ch]) e.hi[ch] = 16'(act_m[k][ch] * CF);
                end
                push_exp(k, e);
            end
        end
        if (wr_en && int'(wr_ch) < NCH) begin
            for (int k = 0; k < 2; k++) tgt_m[k][wr_ch] = int'(wr_data);
        end
    endtask

    task automatic step();
        model_edge();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic write(input int ch, input int data);
        wr_en   = 1'b1;
        wr_ch   = CHW'(ch);
        wr_data = WW'(data);
        step();
        wr_en   = 1'b0;
    endtask

    // Measures each frame window (frame_start to frame_start) and scores it.
    task automatic monitor(input int k);
        int             hi [NCH];
        int             cyc;
        bit             open_w;
        bit             first;
        exp_t           ex;
        logic [NCH-1:0] p;
        logic           fs;
        open_w = 0;
        first  = 0;
        cyc    = 0;
        for (int ch = 0; ch < NCH; ch++) hi[ch] = 0;
        forever begin
            @(posedge clk);
            #1;
            p  = (k == 0) ? pin0 : pin1;
            fs = (k == 0) ? fs0 : fs1;
            if (rst) begin
                chk("reset_pins", k, int'(p), 0);
                chk("reset_frame_start", k, int'(fs), 0);
                open_w = 1;
                first  = 0;
                cyc    = 0;
                for (int ch = 0; ch < NCH; ch++) hi[ch] = 0;
                continue;
            end
            if (open_w) begin
                cyc++;
                for (int ch = 0; ch < NCH; ch++) hi[ch] += int'(p[ch]);
            end
            if (first) begin
                first = 0;
                if (qsize(k) == 0) begin
                    chk("rise_no_expectation", k, 0, 1);
                end else begin
                    ex = qfront(k);
                    for (int ch = 0; ch < NCH; ch++)
                        chk($sformatf("rise_ch%0d", ch), k, int'(p[ch]), int'(ex.hi[ch] != 0));
                end
            end
            if (fs) begin
                if (qsize(k) == 0) begin
                    chk("frame_no_expectation", k, 1, 0);
                end else begin
                    qpop(k, ex);
                    chk("frame_len", k, cyc, PCF);
                    for (int ch = 0; ch < NCH; ch++)
                        chk($sformatf("high_ch%0d", ch), k, hi[ch], int'(ex.hi[ch]));
                end
                open_w = 1;
                first  = 1;
                cyc    = 0;
                for (int ch = 0; ch < NCH; ch++) hi[ch] = 0;
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        // Reset and defaults, channels disabled
        rst = 1'b1;
        run(5);
        rst = 1'b0;
        run(2 * PCF);

        // Enable all, mid-frame write to ch1
        ch_enable = '1;
        run(50);
        write(1, 40);
        run(2 * PCF);

        // Clamp low/high and out-of-range channel
        run(30);
        write(0, 3);
        write(2, 900);
        write(5, 13);
        run(2 * PCF);

        // Slew walk up and back down
        write(0, 30);
        write(2, 30);
        run(4 * PCF);
        write(0, 55);
        run(5 * PCF);
        write(0, 30);
        run(5 * PCF);

        // Write landing exactly on the load edge
        while ((edge_n + 1) % PCF != 0) step();
        write(3, 50);
        run(2 * PCF + 20);

        // Reset while ch1 is high at count 15
        write(1, 45);
        run(PCF);
        while (edge_n % PCF != 30) step();
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(3 * PCF + 10);

        // Randomized writes, enables and occasional reset
        for (int i = 0; i < 10 * PCF; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                wr_en   = 1'b1;
                wr_ch   = CHW'($urandom_range(0, 7));
                wr_data = WW'($urandom_range(0, 120));
            end else begin
                wr_en = 1'b0;
            end
            if ($urandom_range(0, 149) == 0) ch_enable = NCH'($urandom_range(0, 15));
            rst = ($urandom_range(0, 1499) == 0);
            step();
        end
        wr_en = 1'b0;
        rst   = 1'b0;
        run(PCF + 37);

        chk("pending_frames", 0, exp_q0.size(), 1);
        chk("pending_frames", 1, exp_q1.size(), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
